// File: rtl/wb_slave_decoder.sv
// rtl/wb_slave_decoder.sv - Wishbone slave port shared among NSLV peripherals, with decode-miss/timeout fault capture
module wb_slave_decoder #(
  parameter int          NSLV     = 4,
  parameter logic [7:0]  BASE_HI  = 8'h30,
  parameter int          SEL_LSB  = 16,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [NSLV*32-1:0]   s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic                 irq_clr_i,
  output logic                 irq_o,
  output logic [31:0]          fault_adr_o,
  output logic [1:0]           fault_cause_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [2:0]      idx_q, idx_d;
  logic [NSLV-1:0] stb_q, stb_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdat_q, rdat_d;
  logic            irq_q, irq_d;
  logic [31:0]     fadr_q, fadr_d;
  logic [1:0]      fcause_q, fcause_d;

  logic [2:0]  req_idx;
  logic        hit;
  logic        fault_set;
  logic        sel_ack;
  logic [31:0] sel_rdat;

  always_comb begin
    sel_ack  = 1'b0;
    sel_rdat = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == 3'(k)) begin
        sel_ack  = s_ack_i[k];
        sel_rdat = s_dat_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    stb_d     = stb_q;
    ack_d     = 1'b0;
    rdat_d    = rdat_q;
    fadr_d    = fadr_q;
    fcause_d  = fcause_q;
    fault_set = 1'b0;
    req_idx   = wbs_adr_i[SEL_LSB+2:SEL_LSB];
    hit       = (wbs_adr_i[31:24] == BASE_HI) && ({29'd0, req_idx} < 32'(NSLV));

    case (state_q)
      ST_IDLE: begin
        // While ack is still visible the master has not yet retired its strobe.
        if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
          adr_d = wbs_adr_i;
          dat_d = wbs_dat_i;
          we_d  = wbs_we_i;
          sel_d = wbs_sel_i;
          idx_d = req_idx;
          if (hit) begin
            state_d = ST_ACCESS;
            cnt_d   = 8'd0;
            for (int k = 0; k < NSLV; k++) begin
              stb_d[k] = (req_idx == 3'(k));
            end
          end else begin
            state_d   = ST_RESP;
            rdat_d    = ERR_DATA;
            fault_set = 1'b1;
            fadr_d    = wbs_adr_i;
            fcause_d  = 2'd1;
          end
        end
      end
      ST_ACCESS: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
          stb_d   = '0;
        end else if (sel_ack) begin
          state_d = ST_RESP;
          stb_d   = '0;
          rdat_d  = sel_rdat;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          state_d   = ST_RESP;
          stb_d     = '0;
          rdat_d    = ERR_DATA;
          fault_set = 1'b1;
          fadr_d    = adr_q;
          fcause_d  = 2'd2;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        stb_d   = '0;
      end
    endcase

    irq_d = fault_set ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      idx_q    <= '0;
      stb_q    <= '0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      irq_q    <= 1'b0;
      fadr_q   <= '0;
      fcause_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      stb_q    <= stb_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      irq_q    <= irq_d;
      fadr_q   <= fadr_d;
      fcause_q <= fcause_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = rdat_q;
  assign s_cyc_o       = stb_q;
  assign s_stb_o       = stb_q;
  assign s_we_o        = we_q;
  assign s_sel_o       = sel_q;
  assign s_adr_o       = adr_q;
  assign s_dat_o       = dat_q;
  assign irq_o         = irq_q;
  assign fault_adr_o   = fadr_q;
  assign fault_cause_o = fcause_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// tb/tb_wb_slave_decoder.sv - table-driven scoreboard bench for wb_slave_decoder
module tb_wb_slave_decoder;
  localparam int NSLV = 4;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i;
  logic                 wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]           wbs_sel_i;
  logic [31:0]          wbs_adr_i, wbs_dat_i;
  logic                 wbs_ack_o;
  logic [31:0]          wbs_dat_o;
  logic [NSLV-1:0]      s_cyc_o, s_stb_o;
  logic                 s_we_o;
  logic [3:0]           s_sel_o;
  logic [31:0]          s_adr_o, s_dat_o;
  logic [NSLV*32-1:0]   s_dat_i;
  logic [NSLV-1:0]      s_ack_i;
  logic                 irq_clr_i;
  logic                 irq_o;
  logic [31:0]          fault_adr_o;
  logic [1:0]           fault_cause_o;

  wb_slave_decoder #(.NSLV(NSLV)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .irq_clr_i(irq_clr_i), .irq_o(irq_o),
    .fault_adr_o(fault_adr_o), .fault_cause_o(fault_cause_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Peripheral models: ack when the strobe has been high dly[k] cycles (-1 = never).
  int          dly[NSLV];
  int          stb_cnt[NSLV];
  logic [31:0] mem[NSLV];

  always @(posedge wb_clk_i) begin
    for (int k = 0; k < NSLV; k++) begin
      if (wb_rst_i) begin
        mem[k]     <= 32'hA0A0_0000 + 32'(k);
        stb_cnt[k] <= 0;
      end else begin
        stb_cnt[k] <= s_stb_o[k] ? stb_cnt[k] + 1 : 0;
        if (s_stb_o[k] && s_ack_i[k] && s_we_o) mem[k] <= s_dat_o;
      end
    end
  end

  always_comb begin
    s_ack_i = '0;
    s_dat_i = '0;
    for (int k = 0; k < NSLV; k++) begin
      s_ack_i[k] = s_stb_o[k] && (dly[k] >= 0) && (stb_cnt[k] == dly[k]);
      s_dat_i[32*k +: 32] = mem[k];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    int          exp_lat;
    logic [3:0]  exp_stb;
    int          exp_cyc;
    logic        exp_irq;
    logic [1:0]  exp_cause;
    logic [31:0] exp_fadr;
  } vec_t;

  vec_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    vec_t       e;
    int         lat, stb_cyc;
    logic [3:0] stb_seen, sel_seen;
    logic       we_seen;
    bit         got;
    sb.push_back(v);
    wbs_we_i  = v.we;
    wbs_adr_i = v.adr;
    wbs_dat_i = v.dat;
    wbs_sel_i = v.sel;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    tick();
    lat = 0; stb_cyc = 0; stb_seen = '0; sel_seen = '0; we_seen = 1'b0; got = 0;
    for (int c = 0; c < 400; c++) begin
      if (s_stb_o != '0) begin
        stb_cyc++;
        stb_seen |= s_stb_o;
        sel_seen = s_sel_o;
        we_seen  = s_we_o;
      end
      tick();
      lat++;
      if (wbs_ack_o) begin
        got = 1;
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    e = sb.pop_front();
    chk({tag, "_ack_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_dat"}, 64'(wbs_dat_o), 64'(e.exp_dat));
      chk({tag, "_lat"}, 64'(lat), 64'(e.exp_lat));
      chk({tag, "_stb"}, 64'(stb_seen), 64'(e.exp_stb));
      chk({tag, "_stb_cycles"}, 64'(stb_cyc), 64'(e.exp_cyc));
      chk({tag, "_irq"}, 64'(irq_o), 64'(e.exp_irq));
      chk({tag, "_cause"}, 64'(fault_cause_o), 64'(e.exp_cause));
      chk({tag, "_fadr"}, 64'(fault_adr_o), 64'(e.exp_fadr));
      if (e.exp_stb != '0) begin
        chk({tag, "_sel"}, 64'(sel_seen), 64'(e.sel));
        chk({tag, "_we"}, 64'(we_seen), 64'(e.we));
      end
    end
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({wbs_ack_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, irq_o, fault_cause_o}), 64'd0);
    chk({tag, "_wbs_dat"}, 64'(wbs_dat_o), 64'd0);
    chk({tag, "_s_adr"}, 64'(s_adr_o), 64'd0);
    chk({tag, "_s_dat"}, 64'(s_dat_o), 64'd0);
    chk({tag, "_fadr"}, 64'(fault_adr_o), 64'd0);
  endtask

  task automatic clear_irq(input string tag);
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    chk({tag, "_irq_cleared"}, 64'(irq_o), 64'd0);
  endtask

  vec_t tbl[7];
  vec_t v;
  int   acks;
  bit   got;

  initial begin
    tbl[0] = '{1'b1, 32'h3002_0004, 32'h1234_5678, 4'b0110, 32'hA0A0_0002, 2, 4'b0100, 1, 1'b0, 2'd0, 32'h0};
    tbl[1] = '{1'b0, 32'h3002_0004, 32'h0,         4'b1111, 32'h1234_5678, 2, 4'b0100, 1, 1'b0, 2'd0, 32'h0};
    tbl[2] = '{1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'b0011, 32'hA0A0_0000, 2, 4'b0001, 1, 1'b0, 2'd0, 32'h0};
    tbl[3] = '{1'b0, 32'h3003_0000, 32'h0,         4'b1000, 32'hA0A0_0003, 2, 4'b1000, 1, 1'b0, 2'd0, 32'h0};
    tbl[4] = '{1'b0, 32'h4000_0000, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1, 4'b0000, 0, 1'b1, 2'd1, 32'h4000_0000};
    tbl[5] = '{1'b0, 32'h3004_0000, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1, 4'b0000, 0, 1'b1, 2'd1, 32'h3004_0000};
    tbl[6] = '{1'b0, 32'h3000_0000, 32'h0,         4'b1111, 32'h0BAD_F00D, 2, 4'b0001, 1, 1'b1, 2'd1, 32'h3004_0000};

    for (int k = 0; k < NSLV; k++) dly[k] = 0;
    wb_rst_i = 1'b1; irq_clr_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) tick();
    check_zero("reset");
    wb_rst_i = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Clearing the interrupt keeps the captured fault information.
    clear_irq("clr1");
    chk("clr1_fadr_kept", 64'(fault_adr_o), 64'h3004_0000);
    chk("clr1_cause_kept", 64'(fault_cause_o), 64'd1);

    dly[1] = -1;
    v = '{1'b0, 32'h3001_0000, 32'h0, 4'b1111, 32'hDEAD_BEEF, 257, 4'b0010, 256, 1'b1, 2'd2, 32'h3001_0000};
    run_txn("timeout", v);
    clear_irq("clr2");

    dly[1] = 255;
    v = '{1'b0, 32'h3001_0000, 32'h0, 4'b1111, 32'hA0A0_0001, 257, 4'b0010, 256, 1'b0, 2'd2, 32'h3001_0000};
    run_txn("ack_at_timeout", v);

    // Master abort three cycles into ACCESS.
    dly[1] = -1;
    wbs_we_i = 1'b0; wbs_adr_i = 32'h3001_0000; wbs_sel_i = 4'b1111;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    tick();
    repeat (3) tick();
    chk("abort_stb_held", 64'(s_stb_o), 64'b0010);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    chk("abort_stb_drop", 64'({s_cyc_o, s_stb_o}), 64'd0);
    acks = 0;
    repeat (10) begin
      tick();
      if (wbs_ack_o) acks++;
    end
    chk("abort_no_ack", 64'(acks), 64'd0);
    chk("abort_no_irq", 64'(irq_o), 64'd0);
    chk("abort_cause_kept", 64'(fault_cause_o), 64'd2);

    // A fault arriving with irq_clr_i keeps the interrupt asserted.
    v = '{1'b0, 32'h4000_0000, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1, 4'b0000, 0, 1'b1, 2'd1, 32'h4000_0000};
    run_txn("miss_pre", v);
    wbs_adr_i = 32'h5000_0000; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    chk("clr_vs_set_irq", 64'(irq_o), 64'd1);
    chk("clr_vs_set_fadr", 64'(fault_adr_o), 64'h5000_0000);
    got = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wbs_ack_o) begin
        got = 1;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    chk("clr_vs_set_ack", 64'(got), 64'd1);
    chk("clr_vs_set_dat", 64'(wbs_dat_o), 64'hDEAD_BEEF);
    tick();

    // Reset in the middle of an ACCESS.
    dly[2] = -1;
    wbs_adr_i = 32'h3002_0000; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    tick();
    repeat (4) tick();
    chk("rstmid_stb_held", 64'(s_stb_o), 64'b0100);
    wb_rst_i = 1'b1;
    tick();
    check_zero("rstmid");
    wb_rst_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    acks = 0;
    repeat (5) begin
      tick();
      if (wbs_ack_o) acks++;
    end
    chk("rstmid_no_ack", 64'(acks), 64'd0);
    dly[2] = 0;
    v = '{1'b0, 32'h3002_0004, 32'h0, 4'b1111, 32'hA0A0_0002, 2, 4'b0100, 1, 1'b0, 2'd0, 32'h0};
    run_txn("after_rst", v);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
